// File: rtl/mrd_sink_tx.sv
// mrd_sink_tx: buffers upstream sample packets in a FIFO and releases them one at a
// time, as gap-free sop/eop bursts, while the DFT memory top reports idle.
module mrd_sink_tx #(
    parameter int FIFO_AW = 11,
    parameter int GAP_CYC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        s_last,
    input  logic [11:0] s_dftpts,
    input  logic [17:0] s_real,
    input  logic [17:0] s_imag,
    input  logic        dn_idle,
    output logic        o_valid,
    output logic        o_sop,
    output logic        o_eop,
    output logic [17:0] o_real,
    output logic [17:0] o_imag,
    output logic [11:0] o_dftpts,
    output logic        err_len
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam logic [FIFO_AW:0] FIFO_FULL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_SEND, ST_GAP} state_t;

    logic [35:0]        mem_r [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_r;
    logic [FIFO_AW-1:0] rd_ptr_r;
    logic [FIFO_AW:0]   fifo_cnt_r;
    logic [11:0]        hdr_dft_r [2];
    logic [11:0]        hdr_len_r [2];
    logic               hdr_wp_r;
    logic               hdr_rp_r;
    logic [1:0]         hdr_cnt_r;
    logic               in_pkt_r;
    logic [11:0]        in_cnt_r;
    logic [11:0]        pkt_dft_r;
    state_t             state_r;
    state_t             state_nx_s;
    logic [11:0]        rem_r;
    logic [GW-1:0]      gap_cnt_r;
    logic               wr_en_s;
    logic               rd_en_s;
    logic               arm_s;
    logic               hdr_wr_s;
    logic               hdr_rel_s;
    logic [11:0]        beat_cnt_s;
    logic [11:0]        cur_dft_s;

    // Input handshake, saturating beat count and header-write strobes
    always_comb begin
        s_ready    = (fifo_cnt_r != FIFO_FULL) && !((hdr_cnt_r == 2'd2) && !in_pkt_r);
        wr_en_s    = s_valid && s_ready;
        beat_cnt_s = (in_cnt_r == 12'hFFF) ? 12'hFFF : (in_cnt_r + 12'd1);
        cur_dft_s  = in_pkt_r ? pkt_dft_r : s_dftpts;
        hdr_wr_s   = wr_en_s && s_last;
        hdr_rel_s  = o_eop;
    end

    // Upstream packet tracking and length-mismatch pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_pkt_r  <= 1'b0;
            in_cnt_r  <= 12'd0;
            pkt_dft_r <= 12'd0;
            err_len   <= 1'b0;
        end else begin
            err_len <= hdr_wr_s && (beat_cnt_s != cur_dft_s);
            if (wr_en_s) begin
                if (!in_pkt_r) begin
                    pkt_dft_r <= s_dftpts;
                end
                if (s_last) begin
                    in_pkt_r <= 1'b0;
                    in_cnt_r <= 12'd0;
                end else begin
                    in_pkt_r <= 1'b1;
                    in_cnt_r <= beat_cnt_s;
                end
            end
        end
    end

    // Sample storage; contents need no reset since only written entries are read
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= {s_real, s_imag};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fifo_cnt_r <= '0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + 1'b1;
                2'b01:   fifo_cnt_r <= fifo_cnt_r - 1'b1;
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // Two-entry header queue: written on the s_last beat, released on the eop beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hdr_dft_r[0] <= 12'd0;
            hdr_dft_r[1] <= 12'd0;
            hdr_len_r[0] <= 12'd0;
            hdr_len_r[1] <= 12'd0;
            hdr_wp_r     <= 1'b0;
            hdr_rp_r     <= 1'b0;
            hdr_cnt_r    <= 2'd0;
        end else begin
            if (hdr_wr_s) begin
                hdr_dft_r[hdr_wp_r] <= cur_dft_s;
                hdr_len_r[hdr_wp_r] <= beat_cnt_s;
                hdr_wp_r            <= ~hdr_wp_r;
            end
            if (hdr_rel_s) begin
                hdr_rp_r <= ~hdr_rp_r;
            end
            case ({hdr_wr_s, hdr_rel_s})
                2'b10:   hdr_cnt_r <= hdr_cnt_r + 2'd1;
                2'b01:   hdr_cnt_r <= hdr_cnt_r - 2'd1;
                default: hdr_cnt_r <= hdr_cnt_r;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next state and read strobes; SEND keeps one extra cycle while eop is visible
    always_comb begin
        state_nx_s = state_r;
        rd_en_s    = 1'b0;
        arm_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if ((hdr_cnt_r != 2'd0) && dn_idle) begin
                    state_nx_s = ST_ARM;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ARM: begin
                rd_en_s    = 1'b1;
                arm_s      = 1'b1;
                state_nx_s = ST_SEND;
            end
            ST_SEND: begin
                if (rem_r != 12'd0) begin
                    rd_en_s    = 1'b1;
                    state_nx_s = ST_SEND;
                end else begin
                    state_nx_s = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_GAP;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Registered output beat, remaining-beat counter and inter-packet gap counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_valid   <= 1'b0;
            o_sop     <= 1'b0;
            o_eop     <= 1'b0;
            o_real    <= 18'd0;
            o_imag    <= 18'd0;
            o_dftpts  <= 12'd0;
            rem_r     <= 12'd0;
            gap_cnt_r <= '0;
        end else begin
            o_valid <= rd_en_s;
            o_sop   <= arm_s;
            o_eop   <= rd_en_s && (arm_s ? (hdr_len_r[hdr_rp_r] == 12'd1) : (rem_r == 12'd1));
            if (rd_en_s) begin
                {o_real, o_imag} <= mem_r[rd_ptr_r];
            end else begin
                o_real <= 18'd0;
                o_imag <= 18'd0;
            end
            if (arm_s) begin
                o_dftpts <= hdr_dft_r[hdr_rp_r];
                rem_r    <= hdr_len_r[hdr_rp_r] - 12'd1;
            end else if (rd_en_s) begin
                rem_r <= rem_r - 12'd1;
            end else begin
                rem_r <= rem_r;
            end
            if (state_r == ST_GAP) begin
                gap_cnt_r <= gap_cnt_r + 1'b1;
            end else begin
                gap_cnt_r <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mrd_sink_tx.sv
// Scoreboard bench for mrd_sink_tx: the driver queues every accepted beat as the
// expected output beat; a negedge monitor pops and compares, and tracks timing.
module tb_mrd_sink_tx;
    localparam int GAP_CYC = 4;
    localparam int WAIT_MAX = 20000;

    typedef logic [49:0] beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        s_last = 1'b0;
    logic [11:0] s_dftpts = 12'd0;
    logic [17:0] s_real = 18'd0;
    logic [17:0] s_imag = 18'd0;
    logic        dn_idle = 1'b0;
    logic        o_valid, o_sop, o_eop, err_len;
    logic [17:0] o_real, o_imag;
    logic [11:0] o_dftpts;

    mrd_sink_tx #(.FIFO_AW(11), .GAP_CYC(GAP_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
        .s_dftpts(s_dftpts), .s_real(s_real), .s_imag(s_imag), .dn_idle(dn_idle),
        .o_valid(o_valid), .o_sop(o_sop), .o_eop(o_eop), .o_real(o_real), .o_imag(o_imag),
        .o_dftpts(o_dftpts), .err_len(err_len)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int    n_tests = 0;
    int    n_fail = 0;
    beat_t exp_q[$];
    beat_t exp_b;
    int    eop_cyc_q[$];
    bit    mon_en = 1'b0;
    bit    have_eop = 1'b0;
    logic  prev_valid = 1'b0;
    logic  prev_err = 1'b0;
    int    n_beats = 0, n_sops = 0, n_eops = 0, n_err = 0;
    int    last_sop_cyc = 0, last_eop_cyc = 0;
    int    first_acc_cyc = 0, last_acc_cyc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: scoreboard compare, contiguity, gap and err_len width
    always @(negedge clk) begin
        if (mon_en) begin
            if (o_valid) begin
                n_beats++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("beat", {o_sop, o_eop, o_dftpts, o_real, o_imag}, exp_b);
                end
                if (!o_sop) check("contig", prev_valid, 1);
                if (o_sop) begin
                    n_sops++;
                    last_sop_cyc = cyc;
                    if (have_eop) check("gap", (cyc - last_eop_cyc) >= GAP_CYC + 1, 1);
                end
                if (o_eop) begin
                    n_eops++;
                    last_eop_cyc = cyc;
                    have_eop = 1'b1;
                    eop_cyc_q.push_back(cyc);
                end
            end else begin
                check("idle_zero", {o_sop, o_eop, o_real, o_imag}, 0);
            end
            if (err_len) begin
                n_err++;
                check("err_width", prev_err, 0);
            end
            prev_valid = o_valid;
            prev_err = err_len;
        end
    end

    task automatic send_pkt(input int n, input int dft, input int base);
        for (int k = 0; k < n; k++) begin
            int w;
            @(negedge clk);
            s_valid  = 1'b1;
            s_last   = (k == n - 1);
            s_dftpts = dft[11:0];
            s_real   = 18'(base + k);
            s_imag   = 18'(-(base + k));
            w = 0;
            while (!s_ready && w < WAIT_MAX) begin
                @(negedge clk);
                w++;
            end
            if (w >= WAIT_MAX) begin
                check("ready_timeout", 0, 1);
                break;
            end
            if (k == 0) first_acc_cyc = cyc;
            last_acc_cyc = cyc;
            exp_q.push_back({k == 0, k == n - 1, dft[11:0], 18'(base + k), 18'(-(base + k))});
            @(posedge clk);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_sops(input int target, input string tag);
        int w = 0;
        while (n_sops < target && w < WAIT_MAX) begin
            @(negedge clk);
            w++;
        end
        check(tag, n_sops >= target, 1);
    endtask

    task automatic wait_drain(input string tag);
        int w = 0;
        while (exp_q.size() != 0 && w < WAIT_MAX) begin
            @(negedge clk);
            w++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        int s0, b0, e0, r0, ei;
        int w;
        repeat (3) @(negedge clk);
        check("rst_out", {o_valid, o_sop, o_eop, o_real, o_imag, o_dftpts, err_len}, 0);
        check("rst_ready", s_ready, 1);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // 12-pt packet with the engine already idle
        dn_idle = 1'b1;
        e0 = n_err;
        send_pkt(12, 12, 0);
        wait_sops(1, "t1_sop");
        check("t1_lat", last_sop_cyc - last_acc_cyc, 3);
        wait_drain("t1_drain");
        check("t1_err", n_err - e0, 0);

        // 1200-pt packet held back by dn_idle; mid-cycle release is seen by IDLE that cycle
        dn_idle = 1'b0;
        s0 = n_sops;
        b0 = n_beats;
        send_pkt(1200, 1200, 1000);
        repeat (10) @(negedge clk);
        check("t2_hold", n_sops - s0, 0);
        dn_idle = 1'b1;
        r0 = cyc;
        wait_sops(s0 + 1, "t2_sop");
        check("t2_lat", last_sop_cyc - r0, 2);
        wait_drain("t2_drain");
        check("t2_beats", n_beats - b0, 1200);

        // Two buffered 60-pt packets fill the header slots; the third must wait
        dn_idle = 1'b0;
        send_pkt(60, 60, 3000);
        send_pkt(60, 60, 4000);
        ei = eop_cyc_q.size();
        fork
            send_pkt(60, 60, 5000);
            begin
                repeat (4) @(negedge clk);
                check("t3_blocked", s_ready, 0);
                dn_idle = 1'b1;
            end
        join
        check("t3_gate", (eop_cyc_q.size() > ei) && (first_acc_cyc > eop_cyc_q[ei]) &&
              (first_acc_cyc <= eop_cyc_q[ei] + 2), 1);
        wait_drain("t3_drain");

        // Short packet: 24 beats declared as 36
        e0 = n_err;
        send_pkt(24, 36, 6000);
        wait_drain("t4_drain");
        check("t4_err", n_err - e0, 1);

        // Reset in the middle of a 1200-pt send
        b0 = n_beats;
        send_pkt(1200, 1200, 7000);
        w = 0;
        while (n_beats < b0 + 500 && w < WAIT_MAX) begin
            @(negedge clk);
            w++;
        end
        check("t5_reach", n_beats >= b0 + 500, 1);
        mon_en = 1'b0;
        e0 = n_eops;
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_rst_out", {o_valid, o_sop, o_eop, o_real, o_imag, o_dftpts, err_len}, 0);
        check("t5_rst_ready", s_ready, 1);
        rst_n = 1'b1;
        exp_q.delete();
        prev_valid = 1'b0;
        prev_err = 1'b0;
        mon_en = 1'b1;
        repeat (30) @(negedge clk);
        check("t5_no_eop", n_eops - e0, 0);
        b0 = n_beats;
        send_pkt(40, 40, 9000);
        wait_drain("t5_drain");
        check("t5_beats", n_beats - b0, 40);

        // 2048 single-beat packets, crossing the pointer wrap
        b0 = n_beats;
        s0 = n_sops;
        e0 = n_eops;
        for (int k = 0; k < 2048; k++) send_pkt(1, 1, 20000 + k);
        wait_drain("t6_drain");
        check("t6_beats", n_beats - b0, 2048);
        check("t6_sops", n_sops - s0, 2048);
        check("t6_eops", n_eops - e0, 2048);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
